// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the execute stage and the multiply/divide unit.
// The unit's HI/LO write port is carried here as well.
interface muldiv_unit_if;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  op_ready, busy, hi_write, lo_write, hi_data, lo_data
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output op_ready, busy, hi_write, lo_write, hi_data, lo_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine driving the HI/LO write port.
// Multiply latency is MUL_STAGES; divide is a 32-step restoring divider.
module muldiv_unit #(
  parameter int unsigned MUL_STAGES = 1
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_STAGES > 1) ? (MUL_STAGES - 2) : 0);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      prod;
  logic [31:0]      rem;
  logic [31:0]      quo;
  logic [31:0]      dvsr;
  logic             q_neg;
  logic             r_neg;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic [63:0] mul_full;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] r_sh;
  logic [32:0] diff;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] fix_rem;
  logic [31:0] fix_quo;

  // Accept-time operand preparation and one restoring-divide step.
  always_comb begin
    mul_full = 64'd0;
    if (bus.op[0])
      mul_full = {32'd0, bus.src_a} * {32'd0, bus.src_b};
    else
      mul_full = 64'($signed({{32{bus.src_a[31]}}, bus.src_a}) *
                     $signed({{32{bus.src_b[31]}}, bus.src_b}));

    a_neg  = ~bus.op[0] & bus.src_a[31];
    b_neg  = ~bus.op[0] & bus.src_b[31];
    b_zero = (bus.src_b == 32'd0);
    a_mag  = a_neg ? 32'(-bus.src_a) : bus.src_a;
    b_mag  = b_neg ? 32'(-bus.src_b) : bus.src_b;

    r_sh     = {rem, quo[31]};
    diff     = r_sh - {1'b0, dvsr};
    step_rem = r_sh[31:0];
    step_quo = {quo[30:0], 1'b0};
    if (!diff[32]) begin
      step_rem = diff[31:0];
      step_quo = {quo[30:0], 1'b1};
    end

    fix_rem = r_neg ? 32'(-step_rem) : step_rem;
    fix_quo = q_neg ? 32'(-step_quo) : step_quo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.op_valid) begin
          cnt <= '0;
          if (!bus.op[1]) begin
            if (MUL_STAGES <= 1) begin
              {hi_q, lo_q} <= mul_full;
              state        <= DONE;
            end else begin
              prod  <= mul_full;
              state <= MUL;
            end
          end else begin
            // Divide-by-zero runs unsigned on the raw dividend: quotient all ones, remainder = src_a.
            rem   <= '0;
            quo   <= b_zero ? bus.src_a : a_mag;
            dvsr  <= b_mag;
            q_neg <= ~b_zero & (a_neg ^ b_neg);
            r_neg <= ~b_zero & a_neg;
            state <= DIV;
          end
        end
        MUL: begin
          cnt <= CNT_W'(cnt + 1'b1);
          if (cnt == MUL_LAST) begin
            {hi_q, lo_q} <= prod;
            state        <= DONE;
          end
        end
        DIV: begin
          rem <= step_rem;
          quo <= step_quo;
          cnt <= CNT_W'(cnt + 1'b1);
          if (cnt == DIV_LAST) begin
            hi_q  <= fix_rem;
            lo_q  <= fix_quo;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.op_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.hi_write = (state == DONE) & ~bus.flush;
  assign bus.lo_write = (state == DONE) & ~bus.flush;
  assign bus.hi_data  = hi_q;
  assign bus.lo_data  = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned MS = 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_unit_if bus ();

  muldiv_unit #(.MUL_STAGES(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    p  = 64'd0;
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return o[1] ? 33 : int'(MS);
  endfunction

  // Issues one op from an idle unit (called #1 after an edge) and observes its result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output int ready_hi, output bit pair_bad, output bit after_bad);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.src_a    = a;
    bus.src_b    = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    lat = -1; hi = '0; lo = '0; ready_hi = 0; pair_bad = 1'b0; after_bad = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.hi_write !== bus.lo_write) pair_bad = 1'b1;
      if (bus.op_ready !== 1'b0) ready_hi++;
      if (bus.hi_write === 1'b1) begin
        lat = i;
        hi  = bus.hi_data;
        lo  = bus.lo_data;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      after_bad = (bus.hi_write !== 1'b0) || (bus.op_ready !== 1'b1);
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.op_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if ({bus.hi_write, bus.lo_write} !== 2'b00) begin errors++; $display("FAIL reset_strobe: got %b want 00", {bus.hi_write, bus.lo_write}); end
    checks++; if ({bus.hi_data, bus.lo_data} !== 64'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.hi_data, bus.lo_data}); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.op_ready !== 1'b1 || bus.hi_write !== 1'b0) begin errors++; $display("FAIL post_reset_idle: ready=%b hi_write=%b want 1/0", bus.op_ready, bus.hi_write); end
  endtask

  task automatic directed(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat, rdy; logic [31:0] hi, lo; bit pb, ab; logic [63:0] e;
    e = model(o, a, b);
    run_op(o, a, b, lat, hi, lo, rdy, pb, ab);
    checks++; if (lat != exp_lat(o)) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat(o)); end
    checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL %s_result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]); end
    checks++; if (rdy != 0 || pb || ab) begin errors++; $display("FAIL %s_handshake: ready_early=%0d pair_bad=%0b after_bad=%0b want 0/0/0", name, rdy, pb, ab); end
  endtask

  task automatic test_mult();
    directed("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
    checks++; if ({bus.hi_data, bus.lo_data} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_const: got %h want ffffffff_fffffff1", {bus.hi_data, bus.lo_data}); end
  endtask

  task automatic test_back_to_back();
    bus.op_valid = 1'b1; bus.op = 2'b01; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    checks++; if (bus.hi_write !== 1'b1 || bus.op_ready !== 1'b0) begin errors++; $display("FAIL b2b_first_done: hi_write=%b ready=%b want 1/0", bus.hi_write, bus.op_ready); end
    checks++; if ({bus.hi_data, bus.lo_data} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL b2b_multu: got %h want fffffffe_00000001", {bus.hi_data, bus.lo_data}); end
    bus.op = 2'b00; bus.src_a = 32'd7; bus.src_b = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    checks++; if (bus.hi_write !== 1'b0 || bus.op_ready !== 1'b1) begin errors++; $display("FAIL b2b_not_accepted: hi_write=%b ready=%b want 0/1", bus.hi_write, bus.op_ready); end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    checks++; if (bus.hi_write !== 1'b1 || {bus.hi_data, bus.lo_data} !== model(2'b00, 32'd7, 32'hFFFF_FFFE)) begin errors++; $display("FAIL b2b_second: hi_write=%b data=%h want 1/%h", bus.hi_write, {bus.hi_data, bus.lo_data}, model(2'b00, 32'd7, 32'hFFFF_FFFE)); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    directed("divu_100_7", 2'b11, 32'd100, 32'd7);
    checks++; if ({bus.hi_data, bus.lo_data} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_const: got %h want 2/14", {bus.hi_data, bus.lo_data}); end
    directed("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    directed("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++; if ({bus.hi_data, bus.lo_data} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf_const: got %h want 0/80000000", {bus.hi_data, bus.lo_data}); end
    directed("divu_by0", 2'b11, 32'h0000_1234, 32'd0);
    directed("div_by0_neg", 2'b10, 32'hFFFF_FFF0, 32'd0);
    directed("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE);
  endtask

  task automatic test_flush();
    bit seen;
    seen = 1'b0;
    bus.op_valid = 1'b1; bus.op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (bus.hi_write === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.op_ready); end
    for (int i = 0; i < 40; i++) begin
      if (bus.hi_write === 1'b1 || bus.lo_write === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_no_strobe: got strobe want none"); end
    directed("mult_after_flush", 2'b00, 32'd2, 32'd3);

    // Flush landing on the DONE cycle.
    bus.op_valid = 1'b1; bus.op = 2'b00; bus.src_a = 32'd4; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    checks++; if (bus.hi_write !== 1'b1) begin errors++; $display("FAIL flush_done_pre: hi_write=%b want 1", bus.hi_write); end
    bus.flush = 1'b1; #1;
    checks++; if ({bus.hi_write, bus.lo_write} !== 2'b00) begin errors++; $display("FAIL flush_done_strobe: got %b want 00", {bus.hi_write, bus.lo_write}); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.op_ready !== 1'b1 || bus.hi_write !== 1'b0) begin errors++; $display("FAIL flush_done_idle: ready=%b hi_write=%b want 1/0", bus.op_ready, bus.hi_write); end

    // Flush with a request in IDLE blocks acceptance.
    bus.op_valid = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.src_a = 32'd9; bus.src_b = 32'd9;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.op_ready !== 1'b1 || bus.hi_write !== 1'b0) begin errors++; $display("FAIL flush_idle_reject: ready=%b hi_write=%b want 1/0", bus.op_ready, bus.hi_write); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    bus.op_valid = 1'b1; bus.op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd7;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: ready=%b busy=%b want 1/0", bus.op_ready, bus.busy); end
    checks++; if ({bus.hi_write, bus.lo_write, bus.hi_data, bus.lo_data} !== 66'd0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", {bus.hi_write, bus.lo_write, bus.hi_data, bus.lo_data}); end
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      if (bus.hi_write === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_no_strobe: got strobe want none"); end
    directed("divu_9_3", 2'b11, 32'd9, 32'd3);
  endtask

  task automatic test_random();
    logic [31:0] specials [6];
    logic [31:0] a, b;
    logic [1:0]  o;
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 50));
      directed($sformatf("rand%0d_op%0d", n, o), o, a, b);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.op_valid = 1'b0;
    bus.op = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
